// File: rtl/comp_matrix_loader.sv
// comp_matrix_loader
// Collects a serial stream of Q16.16 colour-correction coefficients into a
// shadow register. The complete matrix is copied to comp_matrix in a single
// clock edge, and only when image_processor is idle. A pixel therefore never
// sees a partially updated matrix.
module comp_matrix_loader #(
    parameter int COEF_W = 32,
    parameter int N_COEF = 9,
    parameter int CNT_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COEF_W-1:0]        coef_data,
    input  logic                     coef_valid,
    input  logic                     coef_last,
    output logic                     coef_ready,
    input  logic                     proc_busy,
    output logic [N_COEF*COEF_W-1:0] comp_matrix,
    output logic                     matrix_valid,
    output logic                     commit_pulse,
    output logic                     frame_error,
    output logic [CNT_W-1:0]         load_count
);

    // Side length of the square matrix. The words are stored row-major.
    localparam int DIM = 3;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_COEF - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_COEF);

    // Q16.16 identity matrix: 1.0 on the diagonal, 0 everywhere else.
    function automatic logic [N_COEF*COEF_W-1:0] identity_matrix();
        logic [N_COEF*COEF_W-1:0] m;
        m = '0;
        for (int k = 0; k < N_COEF; k++) begin
            if ((k / DIM) == (k % DIM)) begin
                m[k*COEF_W +: COEF_W] = COEF_W'(32'h0001_0000);
            end
        end
        return m;
    endfunction

    localparam logic [N_COEF*COEF_W-1:0] IDENTITY = identity_matrix();

    typedef enum logic {
        S_LOAD,
        S_PENDING
    } state_t;

    state_t            state;
    logic [COEF_W-1:0] shadow [N_COEF];

    // The loader accepts words in every cycle except while it waits to commit.
    assign coef_ready = (state == S_LOAD);

    // Load/commit FSM. All outputs are registered inside this block.
    // NOTE: every register in this block uses non-blocking assignments. Each
    // right-hand side therefore sees the value from before the edge, even
    // when another statement in the block updates the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_LOAD;
            load_count   <= '0;
            comp_matrix  <= IDENTITY;
            matrix_valid <= 1'b0;
            commit_pulse <= 1'b0;
            frame_error  <= 1'b0;
            // NOTE: the shadow array is reset on purpose. A reset must leave
            // no stale coefficients behind, so this small array is not left
            // uninitialised the way a large RAM would be.
            for (int k = 0; k < N_COEF; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            commit_pulse <= 1'b0;
            frame_error  <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (coef_valid) begin
                        if ((load_count == LAST_IDX) && coef_last) begin
                            shadow[load_count] <= coef_data;
                            load_count         <= FULL_CNT;
                            state              <= S_PENDING;
                        end else if ((load_count == LAST_IDX) || coef_last) begin
                            // The frame ended too early or ran too long.
                            // Drop the whole load and start again at word 0.
                            frame_error <= 1'b1;
                            load_count  <= '0;
                            for (int k = 0; k < N_COEF; k++) begin
                                shadow[k] <= '0;
                            end
                        end else begin
                            shadow[load_count] <= coef_data;
                            load_count         <= load_count + CNT_W'(1);
                        end
                    end
                end
                S_PENDING: begin
                    if (!proc_busy) begin
                        for (int k = 0; k < N_COEF; k++) begin
                            comp_matrix[k*COEF_W +: COEF_W] <= shadow[k];
                        end
                        matrix_valid <= 1'b1;
                        commit_pulse <= 1'b1;
                        load_count   <= '0;
                        state        <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_comp_matrix_loader.sv
// Testbench for comp_matrix_loader. Directed scenarios and random traffic are
// compared against a transaction-level model built from a queue of accepted
// words.
module tb_comp_matrix_loader;

    localparam int COEF_W = 32;
    localparam int N_COEF = 9;
    localparam int CNT_W  = 4;
    localparam int MW     = N_COEF * COEF_W;

    logic              clk;
    logic              rst_n;
    logic [COEF_W-1:0] coef_data;
    logic              coef_valid;
    logic              coef_last;
    logic              coef_ready;
    logic              proc_busy;
    logic [MW-1:0]     comp_matrix;
    logic              matrix_valid;
    logic              commit_pulse;
    logic              frame_error;
    logic [CNT_W-1:0]  load_count;

    comp_matrix_loader #(
        .COEF_W(COEF_W),
        .N_COEF(N_COEF),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coef_data   (coef_data),
        .coef_valid  (coef_valid),
        .coef_last   (coef_last),
        .coef_ready  (coef_ready),
        .proc_busy   (proc_busy),
        .comp_matrix (comp_matrix),
        .matrix_valid(matrix_valid),
        .commit_pulse(commit_pulse),
        .frame_error (frame_error),
        .load_count  (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the words accepted so far, plus the committed matrix.
    logic [31:0] mq [$];
    logic [31:0] m_mat [N_COEF];
    bit          m_pending;
    bit          m_valid;
    bit          m_commit;
    bit          m_ferr;

    task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] model_flat();
        logic [MW-1:0] f;
        for (int k = 0; k < N_COEF; k++) f[k*COEF_W +: COEF_W] = m_mat[k];
        return f;
    endfunction

    function automatic void model_reset();
        mq.delete();
        for (int k = 0; k < N_COEF; k++) m_mat[k] = (k == 0 || k == 4 || k == 8) ? 32'h0001_0000 : 32'h0;
        m_pending = 0;
        m_valid   = 0;
        m_commit  = 0;
        m_ferr    = 0;
    endfunction

    // Advance the model by one clock edge, using the inputs seen at that edge.
    function automatic void model_edge(input logic v, input logic [31:0] d, input logic l, input logic b);
        m_commit = 0;
        m_ferr   = 0;
        if (m_pending) begin
            if (!b) begin
                for (int k = 0; k < N_COEF; k++) m_mat[k] = mq[k];
                mq.delete();
                m_valid   = 1;
                m_commit  = 1;
                m_pending = 0;
            end
        end else if (v) begin
            mq.push_back(d);
            if (mq.size() == N_COEF) begin
                if (l) m_pending = 1;
                else begin m_ferr = 1; mq.delete(); end
            end else if (l) begin
                m_ferr = 1;
                mq.delete();
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".load_count"}, load_count, mq.size());
        check({tag, ".matrix_valid"}, matrix_valid, m_valid);
        check({tag, ".commit_pulse"}, commit_pulse, m_commit);
        check({tag, ".frame_error"}, frame_error, m_ferr);
        check({tag, ".comp_matrix"}, comp_matrix, model_flat());
    endtask

    // One clock cycle. The task is entered 1 time unit after a rising edge:
    // it drives the inputs, checks ready mid-cycle, then checks the outputs
    // 1 time unit after the next edge.
    task automatic step(input string tag, input logic v, input logic [31:0] d, input logic l, input logic b);
        coef_valid = v;
        coef_data  = d;
        coef_last  = l;
        proc_busy  = b;
        #3;
        check({tag, ".coef_ready"}, coef_ready, !m_pending);
        @(posedge clk);
        model_edge(v, d, l, b);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n      = 1'b0;
        coef_valid = 1'b0;
        coef_last  = 1'b0;
        proc_busy  = 1'b0;
        model_reset();
        #2;
        check_outputs({tag, ".in_reset"});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check({tag, ".ready_after"}, coef_ready, 1'b1);
        check_outputs({tag, ".after"});
        @(posedge clk);
        #1;
    endtask

    // Sends words w[0..n-1]; coef_last is raised on index last_at (-1 means never).
    task automatic send_words(input string tag, input logic [31:0] w [N_COEF], input int n,
                              input int last_at, input int gap_pct, input logic b);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) step(tag, 1'b0, $urandom, 1'($urandom), b);
            step(tag, 1'b1, w[i], (i == last_at), b);
        end
    endtask

    logic [31:0] spec_w [N_COEF];
    logic [31:0] rnd_w  [N_COEF];

    task automatic fill_random();
        for (int k = 0; k < N_COEF; k++) rnd_w[k] = $urandom;
    endtask

    initial begin
        logic        pv;
        logic [31:0] pd;
        logic        pl;
        logic        v;
        logic        l;
        logic [31:0] d;

        spec_w = '{32'h0001_1999, 32'h0, 32'h0, 32'h0, 32'h0001_0CCC, 32'h0, 32'h0, 32'h0, 32'h0000_E666};
        rst_n      = 1'b1;
        coef_valid = 1'b0;
        coef_data  = '0;
        coef_last  = 1'b0;
        proc_busy  = 1'b0;
        #1;

        // 1: reset values
        do_reset("t1");
        check("t1.m00", comp_matrix[31:0], 32'h0001_0000);
        check("t1.m11", comp_matrix[159:128], 32'h0001_0000);
        check("t1.m22", comp_matrix[287:256], 32'h0001_0000);
        check("t1.m01", comp_matrix[63:32], 32'h0);

        // 2: full load, image_processor idle
        send_words("t2", spec_w, 9, 8, 0, 1'b0);
        check("t2.ready_low", coef_ready, 1'b0);
        step("t2c", 1'b0, 32'h0, 1'b0, 1'b0);
        check("t2.m00", comp_matrix[31:0], 32'h0001_1999);
        check("t2.m11", comp_matrix[159:128], 32'h0001_0CCC);
        check("t2.m22", comp_matrix[287:256], 32'h0000_E666);
        check("t2.pulse", commit_pulse, 1'b1);
        check("t2.valid", matrix_valid, 1'b1);
        step("t2d", 1'b0, 32'h0, 1'b0, 1'b0);
        check("t2.pulse_once", commit_pulse, 1'b0);

        // 3: commit held off while busy (busy during LOAD is ignored)
        fill_random();
        send_words("t3", rnd_w, 9, 8, 0, 1'b1);
        for (int i = 0; i < 20; i++) step("t3b", 1'b1, $urandom, 1'b1, 1'b1);
        step("t3c", 1'b0, 32'h0, 1'b0, 1'b0);
        check("t3.pulse", commit_pulse, 1'b1);
        check("t3.m22", comp_matrix[287:256], rnd_w[8]);

        // 4: coef_last on the 5th word, then a correct load
        fill_random();
        send_words("t4", rnd_w, 5, 4, 0, 1'b0);
        check("t4.ferr", frame_error, 1'b1);
        step("t4e", 1'b0, 32'h0, 1'b0, 1'b0);
        check("t4.ferr_once", frame_error, 1'b0);
        send_words("t4b", spec_w, 9, 8, 20, 1'b0);
        step("t4c", 1'b0, 32'h0, 1'b0, 1'b0);
        check("t4.m11", comp_matrix[159:128], 32'h0001_0CCC);

        // 5: ninth word without coef_last
        fill_random();
        send_words("t5", rnd_w, 9, -1, 0, 1'b0);
        check("t5.ferr", frame_error, 1'b1);
        step("t5e", 1'b0, 32'h0, 1'b0, 1'b0);

        // 6: reset mid-load with gaps, reset while pending, then a full load
        fill_random();
        send_words("t6", rnd_w, 4, -1, 40, 1'b0);
        do_reset("t6r");
        fill_random();
        send_words("t6p", rnd_w, 9, 8, 30, 1'b1);
        step("t6q", 1'b0, 32'h0, 1'b0, 1'b1);
        do_reset("t6s");
        fill_random();
        send_words("t6b", rnd_w, 9, 8, 40, 1'b0);
        step("t6c", 1'b0, 32'h0, 1'b0, 1'b0);
        check("t6.m00", comp_matrix[31:0], rnd_w[0]);

        // Random traffic: the data and last flag are held while a word is stalled.
        pv = 0; pd = '0; pl = 0;
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(99) < 70);
            d = $urandom;
            l = (mq.size() == N_COEF - 1) ? ($urandom_range(9) != 0) : ($urandom_range(29) == 0);
            if (m_pending && pv) begin
                v = 1'b1; d = pd; l = pl;
            end
            step("rnd", v, d, l, 1'($urandom));
            pv = v; pd = d; pl = l;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
